// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one port of a read-first BRAM among NUM_REQ requesters, with an optional lock for read-modify-write.
// Latency: the grant and BRAM drive are combinational in the request cycle; read data returns with rsp_valid_o exactly 1 cycle later.
// Backpressure: requesters hold valid and payload until req_ready_o; read responses cannot be stalled.
module bram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 32,
    localparam int ADDR_W    = $clog2(NUM_WORDS),
    localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0]                   req_we_i,
    input  logic [NUM_REQ-1:0]                   req_lock_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]       req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]                   rsp_valid_o,
    output logic [DATA_WIDTH-1:0]                rsp_rdata_o,
    output logic                                 bram_en_o,
    output logic                                 bram_we_o,
    output logic [ADDR_W-1:0]                    bram_addr_o,
    output logic [DATA_WIDTH-1:0]                bram_wdata_o,
    input  logic [DATA_WIDTH-1:0]                bram_rdata_i
);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    r_owner;
    logic [NUM_REQ-1:0]  r_rsp_vld;

    logic                w_found;
    logic [PTR_W-1:0]    w_grant_idx;
    logic [PTR_W-1:0]    w_next_ptr;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_xfer;
    int                  w_scan_idx;

    // Pick the winner: the owner alone while locked, otherwise the first valid index at or after the round-robin pointer.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = 0;
        if (r_state == ST_LOCKED) begin
            if (req_valid_i[r_owner]) begin
                w_found     = 1'b1;
                w_grant_idx = r_owner;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_scan_idx = int'(r_rr_ptr) + i;
                if (w_scan_idx >= NUM_REQ) begin
                    w_scan_idx = w_scan_idx - NUM_REQ;
                end
                if (!w_found && req_valid_i[PTR_W'(w_scan_idx)]) begin
                    w_found     = 1'b1;
                    w_grant_idx = PTR_W'(w_scan_idx);
                end
            end
        end
    end

    // Expand the winner to a one-hot grant; nothing is granted while reset is held so no transfer can slip through.
    always_comb begin
        w_grant = '0;
        if (w_found && rst_ni) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign w_xfer      = |w_grant;
    assign req_ready_o = w_grant;

    // Pointer position just past the winner, wrapping at NUM_REQ-1 even when NUM_REQ is not a power of two.
    always_comb begin
        if (w_grant_idx == PTR_W'(NUM_REQ - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_grant_idx + PTR_W'(1);
        end
    end

    // Steer the granted request straight onto the BRAM port; address and data are zeroed when idle to keep the bus quiet.
    always_comb begin
        bram_en_o    = w_xfer;
        bram_we_o    = 1'b0;
        bram_addr_o  = '0;
        bram_wdata_o = '0;
        if (w_xfer) begin
            bram_we_o    = req_we_i[w_grant_idx];
            bram_addr_o  = req_addr_i[w_grant_idx];
            bram_wdata_o = req_wdata_i[w_grant_idx];
        end
    end

    // Arbitration state, pointer, lock owner and the one-cycle read response pipeline.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_ARB;
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_rsp_vld <= '0;
        end else begin
            // A read granted now is answered next cycle, when the registered BRAM output holds its data.
            r_rsp_vld <= w_grant & ~req_we_i;
            case (r_state)
                ST_ARB: begin
                    if (w_xfer) begin
                        r_rr_ptr <= w_next_ptr;
                        if (req_lock_i[w_grant_idx]) begin
                            r_state <= ST_LOCKED;
                            r_owner <= w_grant_idx;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Only the owner can transfer here; the pointer stays frozen until the unlocking transfer.
                    if (w_xfer && !req_lock_i[w_grant_idx]) begin
                        r_state  <= ST_ARB;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

    assign rsp_valid_o = r_rsp_vld;
    assign rsp_rdata_o = bram_rdata_i;

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

    logic              clk;
    logic              rst_n;
    logic [3:0]        v;
    logic [3:0]        we;
    logic [3:0]        lk;
    logic [3:0][4:0]   addr;
    logic [3:0][31:0]  wd;
    logic [3:0]        ready;
    logic [3:0]        rsp;
    logic [31:0]       rdata;
    logic              b_en;
    logic              b_we;
    logic [4:0]        b_addr;
    logic [31:0]       b_wdata;
    logic [31:0]       b_rdata;
    logic [31:0]       mem [0:31];

    int n_assert = 0;
    int n_fail   = 0;

    bram_port_arbiter #(
        .NUM_REQ(4),
        .DATA_WIDTH(32),
        .NUM_WORDS(32)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_valid_i(v),
        .req_ready_o(ready),
        .req_we_i(we),
        .req_lock_i(lk),
        .req_addr_i(addr),
        .req_wdata_i(wd),
        .rsp_valid_o(rsp),
        .rsp_rdata_o(rdata),
        .bram_en_o(b_en),
        .bram_we_o(b_we),
        .bram_addr_o(b_addr),
        .bram_wdata_o(b_wdata),
        .bram_rdata_i(b_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first BRAM port: registered output returns the old word; contents refill with 0x1000_0000+addr during reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (b_en) begin
            b_rdata <= mem[b_addr];
            if (b_we) mem[b_addr] <= b_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check grant and response for the current cycle; read data only matters when a response is expected.
    task automatic step(input string tag, input logic [3:0] e_ready, input logic [3:0] e_rsp, input logic [31:0] e_rdata);
        chk({tag, "_ready"}, 32'(ready), 32'(e_ready));
        chk({tag, "_rsp"}, 32'(rsp), 32'(e_rsp));
        if (e_rsp != 4'b0000) chk({tag, "_rdata"}, rdata, e_rdata);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; v = '0; we = '0; lk = '0; addr = '0; wd = '0;
        tick(); tick(); #1;
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_rsp", 32'(rsp), 32'h0);
        chk("rst_en", 32'(b_en), 32'h0);
        chk("rst_we", 32'(b_we), 32'h0);

        // All four read addrs 0..3, held: grants rotate 0,1,2,3,0.
        tick(); rst_n = 1'b1; v = 4'b1111;
        addr[0] = 5'd0; addr[1] = 5'd1; addr[2] = 5'd2; addr[3] = 5'd3; #1;
        step("t1a", 4'b0001, 4'b0000, 32'h0);
        chk("t1a_en", 32'(b_en), 32'h1);
        chk("t1a_addr", 32'(b_addr), 32'd0);
        tick(); #1; step("t1b", 4'b0010, 4'b0001, 32'h1000_0000);
        chk("t1b_addr", 32'(b_addr), 32'd1);
        tick(); #1; step("t1c", 4'b0100, 4'b0010, 32'h1000_0001);
        tick(); #1; step("t1d", 4'b1000, 4'b0100, 32'h1000_0002);
        tick(); #1; step("t1e", 4'b0001, 4'b1000, 32'h1000_0003);
        tick(); v = 4'b0000; #1; step("t1f", 4'b0000, 4'b0001, 32'h1000_0000);
        chk("t1f_en", 32'(b_en), 32'h0);

        // Req1 writes DEADBEEF to 5, req2 reads it back.
        tick(); v = 4'b0010; we = 4'b0010; addr[1] = 5'd5; wd[1] = 32'hDEAD_BEEF; #1;
        step("t2w", 4'b0010, 4'b0000, 32'h0);
        chk("t2w_bwe", 32'(b_we), 32'h1);
        chk("t2w_addr", 32'(b_addr), 32'd5);
        chk("t2w_wdata", b_wdata, 32'hDEAD_BEEF);
        tick(); v = 4'b0100; we = 4'b0000; addr[2] = 5'd5; #1;
        step("t2r", 4'b0100, 4'b0000, 32'h0);
        chk("t2r_bwe", 32'(b_we), 32'h0);
        tick(); v = 4'b0000; #1; step("t2rsp", 4'b0000, 4'b0100, 32'hDEAD_BEEF);

        // Req2 locks; req0/req3 locked out (req0 lock ignored); unlocking write; then req3, req0.
        tick(); v = 4'b0100; lk = 4'b0100; #1; step("t3lock", 4'b0100, 4'b0000, 32'h0);
        tick(); v = 4'b1001; lk = 4'b0001; #1; step("t3idle", 4'b0000, 4'b0100, 32'hDEAD_BEEF);
        tick(); v = 4'b1101; lk = 4'b0000; we = 4'b0100; addr[2] = 5'd7; wd[2] = 32'hCAFE_F00D; #1;
        step("t3unl", 4'b0100, 4'b0000, 32'h0);
        chk("t3unl_bwe", 32'(b_we), 32'h1);
        chk("t3unl_addr", 32'(b_addr), 32'd7);
        tick(); v = 4'b1001; we = 4'b0000; addr[3] = 5'd7; addr[0] = 5'd0; #1;
        step("t3r3", 4'b1000, 4'b0000, 32'h0);
        tick(); v = 4'b0001; #1; step("t3r0", 4'b0001, 4'b1000, 32'hCAFE_F00D);

        // Only req3 for three cycles, then req0 wins after the wrap.
        tick(); v = 4'b1000; #1; step("t5a", 4'b1000, 4'b0001, 32'h1000_0000);
        tick(); #1; step("t5b", 4'b1000, 4'b1000, 32'hCAFE_F00D);
        tick(); #1; step("t5c", 4'b1000, 4'b1000, 32'hCAFE_F00D);
        tick(); v = 4'b1001; #1; step("t5wrap", 4'b0001, 4'b1000, 32'hCAFE_F00D);

        // Read grant to req0 cut by reset: no response, ready low, pointer back to 0.
        tick(); v = 4'b0001; #1; step("t4g", 4'b0001, 4'b0001, 32'h1000_0000);
        #1; rst_n = 1'b0; #1;
        chk("t4_rdy_rst", 32'(ready), 32'h0);
        chk("t4_en_rst", 32'(b_en), 32'h0);
        chk("t4_rsp_rst", 32'(rsp), 32'h0);
        tick(); v = 4'b0011; #1; step("t4hold", 4'b0000, 4'b0000, 32'h0);
        tick(); rst_n = 1'b1; #1; step("t4rel", 4'b0001, 4'b0000, 32'h0);
        tick(); v = 4'b0000; #1; step("t4rsp", 4'b0000, 4'b0001, 32'h1000_0000);
        tick(); #1; step("t4quiet", 4'b0000, 4'b0000, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
